// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: shared state encoding, tipo/alucontrol codes, storage depths and immediate sign-extension
package exec_stage_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, EX = 2'b01, MEM = 2'b10, WB = 2'b11} state_t;
  localparam logic [2:0] T_I = 3'b000;
  localparam logic [2:0] T_S = 3'b010;
  localparam logic [2:0] T_R = 3'b011;
  localparam logic [2:0] T_SB = 3'b110;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam int NREG = 32;
  localparam int NMEM = 64;
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction
endpackage

// File: rtl/exec_stage_if.sv
// exec_stage_if: decoded-instruction handshake in (in_valid/in_ready, fields, pc) and retire results out (done, branch_taken, pc_next, wb_rd, wb_data); master = issuer, slave = stage
interface exec_stage_if;
  logic in_valid, in_ready;
  logic [2:0] tipo;
  logic [3:0] alucontrol;
  logic regiwrite, memread, memwrite, branch;
  logic [4:0] rd, rs1, rs2;
  logic [11:0] immediate;
  logic [31:0] pc;
  logic done, branch_taken;
  logic [31:0] pc_next;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  modport master (
    output in_valid, tipo, alucontrol, regiwrite, memread, memwrite, branch, rd, rs1, rs2, immediate, pc,
    input in_ready, done, branch_taken, pc_next, wb_rd, wb_data
  );
  modport slave (
    input in_valid, tipo, alucontrol, regiwrite, memread, memwrite, branch, rd, rs1, rs2, immediate, pc,
    output in_ready, done, branch_taken, pc_next, wb_rd, wb_data
  );
endinterface

// File: rtl/exec_stage_alu.sv
// alu: combinational 32-bit ALU (op 4b, a/b 32b in, y 32b out); unknown ops add
module alu
  import exec_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = op == ALU_SUB ? a - b :
        op == ALU_XOR ? a ^ b :
        op == ALU_SRL ? a >> b[4:0] : a + b;
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: IDLE/EX/MEM/WB execute stage with 32x32 regfile and 64-word data memory; ports clk, rst_n (async low), bus (exec_stage_if.slave)
module exec_stage
  import exec_stage_pkg::*;
(
  input logic clk,
  input logic rst_n,
  exec_stage_if.slave bus
);
  state_t state_q, state_d;
  logic [2:0] tipo_q;
  logic [3:0] op_q;
  logic regw_q, mr_q, mw_q, br_q, taken_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [11:0] imm_q;
  logic [31:0] pc_q, rv1, rv2, opb, alu_y, res_q, mdata_q, wdata;
  logic [31:0] rf [NREG];
  logic [31:0] dm [NMEM];
  assign rv1 = rf[rs1_q];
  assign rv2 = rf[rs2_q];
  assign opb = (tipo_q == T_I || tipo_q == T_S) ? sext12(imm_q) : rv2;
  assign wdata = mr_q ? mdata_q : res_q;
  assign bus.in_ready = state_q == IDLE;
  alu u_alu (.op(op_q), .a(rv1), .b(opb), .y(alu_y));
  always_comb begin
    state_d = state_q == IDLE ? (bus.in_valid ? EX : IDLE) :
              state_q == EX   ? ((mr_q | mw_q) ? MEM : WB) :
              state_q == MEM  ? WB : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {tipo_q, op_q, regw_q, mr_q, mw_q, br_q, rd_q, rs1_q, rs2_q, imm_q, pc_q} <= '0;
      {res_q, mdata_q, taken_q} <= '0;
      bus.done <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.pc_next <= '0;
      bus.wb_rd <= '0;
      bus.wb_data <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      bus.done <= state_q == WB;
      if (state_q == IDLE && bus.in_valid)
        {tipo_q, op_q, regw_q, mr_q, mw_q, br_q, rd_q, rs1_q, rs2_q, imm_q, pc_q} <=
          {bus.tipo, bus.alucontrol, bus.regiwrite, bus.memread, bus.memwrite, bus.branch,
           bus.rd, bus.rs1, bus.rs2, bus.immediate, bus.pc};
      if (state_q == EX) begin
        res_q <= alu_y;
        taken_q <= br_q && rv1 == rv2;
      end
      if (state_q == MEM) mdata_q <= dm[res_q[7:2]];
      if (state_q == WB) begin
        bus.branch_taken <= taken_q;
        bus.pc_next <= taken_q ? pc_q + (sext12(imm_q) << 1) : pc_q + 32'd4;
        if (regw_q && rd_q != 5'd0) begin
          rf[rd_q] <= wdata;
          bus.wb_rd <= rd_q;
          bus.wb_data <= wdata;
        end
      end
    end
  end
  // rst_n gate keeps a reset that lands in MEM from committing the store
  always_ff @(posedge clk) begin
    if (rst_n && state_q == MEM && mw_q) dm[res_q[7:2]] <= rv2;
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and randomized checks of exec_stage against an instruction-level reference model
module tb_exec_stage;
  import exec_stage_pkg::*;
  typedef struct packed {
    logic [2:0] tipo;
    logic [3:0] op;
    logic regw, mr, mw, br;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] pc;
  } instr_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];
  logic [31:0] mmem [64];
  logic [4:0] m_wb_rd;
  logic [31:0] m_wb_data;
  exec_stage_if bus();
  exec_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic instr_t mk(logic [2:0] t, logic [3:0] op, logic regw, logic mr, logic mw, logic br,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm, logic [31:0] pc);
    return '{tipo: t, op: op, regw: regw, mr: mr, mw: mw, br: br, rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: pc};
  endfunction
  function automatic instr_t addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return mk(T_I, ALU_ADD, 1, 0, 0, 0, rd, rs1, 0, imm, 0);
  endfunction
  function automatic instr_t rop(logic [3:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return mk(T_R, op, 1, 0, 0, 0, rd, rs1, rs2, 0, 0);
  endfunction
  function automatic instr_t lw(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return mk(T_I, ALU_ADD, 1, 1, 0, 0, rd, rs1, 0, imm, 0);
  endfunction
  function automatic instr_t sw(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return mk(T_S, ALU_ADD, 0, 0, 1, 0, 0, rs1, rs2, imm, 0);
  endfunction
  function automatic instr_t beq(logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm, logic [31:0] pc);
    return mk(T_SB, ALU_SUB, 0, 0, 0, 1, 0, rs1, rs2, imm, pc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    m_wb_rd = 0;
    m_wb_data = 0;
  endtask

  task automatic model(input instr_t i, output logic et, output logic [31:0] ep);
    logic [31:0] a, b2, s, b, r, d;
    int idx;
    a = mregs[i.rs1];
    b2 = mregs[i.rs2];
    s = {{20{i.imm[11]}}, i.imm};
    b = (i.tipo == T_I || i.tipo == T_S) ? s : b2;
    case (i.op)
      ALU_SUB: r = a - b;
      ALU_XOR: r = a ^ b;
      ALU_SRL: r = a >> (b % 32);
      default: r = a + b;
    endcase
    idx = int'((r / 4) % 64);
    if (i.mw) mmem[idx] = b2;
    d = i.mr ? mmem[idx] : r;
    if (i.regw && i.rd != 0) begin
      mregs[i.rd] = d;
      m_wb_rd = i.rd;
      m_wb_data = d;
    end
    et = i.br && a == b2;
    ep = et ? i.pc + s * 2 : i.pc + 4;
  endtask

  task automatic drive(input instr_t i);
    bus.tipo = i.tipo; bus.alucontrol = i.op; bus.regiwrite = i.regw; bus.memread = i.mr;
    bus.memwrite = i.mw; bus.branch = i.br; bus.rd = i.rd; bus.rs1 = i.rs1; bus.rs2 = i.rs2;
    bus.immediate = i.imm; bus.pc = i.pc;
  endtask

  task automatic wait_done(input string tag, input int want_lat);
    int e;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
    end while (!bus.done && e < 6);
    chk({tag, " latency"}, e, want_lat);
  endtask

  task automatic chk_out(input string tag, input logic et, input logic [31:0] ep);
    chk({tag, " taken"}, bus.branch_taken, et);
    chk({tag, " pc_next"}, bus.pc_next, ep);
    chk({tag, " wb_rd"}, bus.wb_rd, m_wb_rd);
    chk({tag, " wb_data"}, bus.wb_data, m_wb_data);
  endtask

  task automatic run(input instr_t i, input string tag);
    logic et;
    logic [31:0] ep;
    @(negedge clk);
    chk({tag, " ready"}, bus.in_ready, 1);
    drive(i);
    bus.in_valid = 1;
    @(posedge clk); #1 bus.in_valid = 0;
    chk({tag, " busy"}, bus.in_ready, 0);
    model(i, et, ep);
    wait_done(tag, (i.mr | i.mw) ? 3 : 2);
    chk_out(tag, et, ep);
    @(posedge clk); #1 chk({tag, " pulse"}, bus.done, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"}, bus.in_ready, 1);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " taken"}, bus.branch_taken, 0);
    chk({tag, " pc_next"}, bus.pc_next, 0);
    chk({tag, " wb_rd"}, bus.wb_rd, 0);
    chk({tag, " wb_data"}, bus.wb_data, 0);
  endtask

  initial begin
    logic et;
    logic [31:0] ep;
    instr_t ia, ib, ir;
    int k;
    logic [3:0] op;
    logic [4:0] ra, rb, rdr;
    rst_n = 0;
    bus.in_valid = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1;

    run(addi(1, 0, 5), "addi x1");
    run(addi(2, 0, 3), "addi x2");
    run(rop(ALU_SUB, 3, 1, 2), "sub x3");
    run(rop(ALU_XOR, 4, 1, 2), "xor x4");
    run(addi(2, 0, 1), "addi x2=1");
    run(rop(ALU_SRL, 5, 1, 2), "srl x5");
    run(sw(1, 0, 8), "sw x1");
    run(lw(6, 0, 8), "lw x6");
    run(beq(1, 1, 4, 16), "beq taken");
    run(beq(1, 2, 4, 16), "beq not");
    run(addi(0, 0, 7), "addi x0");
    run(addi(7, 0, 9), "read x0");
    run(rop(ALU_ADD, 8, 7, 1), "back2back");
    run(rop(4'b1111, 9, 1, 2), "undef op");
    run(addi(10, 0, 12'hffe), "neg imm");
    run(rop(ALU_SUB, 11, 0, 1), "sub wrap");

    // second instruction held on in_valid throughout the first one
    ia = addi(12, 0, 11);
    ib = addi(12, 0, 22);
    @(negedge clk);
    drive(ia);
    bus.in_valid = 1;
    @(posedge clk); #1 drive(ib);
    chk("hold busy", bus.in_ready, 0);
    model(ia, et, ep);
    wait_done("hold A", 2);
    chk_out("hold A", et, ep);
    chk("hold A ready", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 0;
    model(ib, et, ep);
    wait_done("hold B", 2);
    chk_out("hold B", et, ep);
    @(posedge clk); #1 chk("hold B pulse", bus.done, 0);

    // reset during MEM of a store to word 2
    @(negedge clk);
    drive(sw(2, 0, 8));
    bus.in_valid = 1;
    @(posedge clk); #1 bus.in_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    model_reset();
    #1 chk_reset("mid reset");
    @(negedge clk) rst_n = 1;
    run(lw(6, 0, 8), "lw after reset");

    for (int w = 0; w < 64; w++) begin
      run(addi(10, 0, 12'($urandom)), "fill val");
      run(sw(10, 0, 12'(w * 4)), "fill sw");
    end
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 4));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rdr = 5'($urandom_range(0, 7));
      op = 4'($urandom);
      case (k)
        0: ir = rop(op, rdr, ra, rb);
        1: begin
          ir = addi(rdr, ra, 12'($urandom));
          ir.op = op == ALU_SRL ? ALU_ADD : op;
        end
        2: ir = lw(rdr, ra, 12'($urandom));
        3: ir = sw(rb, ra, 12'($urandom));
        default: ir = beq(ra, $urandom_range(0, 1) == 0 ? ra : rb, 12'($urandom), 0);
      endcase
      ir.pc = $urandom & 32'hffff_fffc;
      run(ir, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
